// File: rtl/pulpemu_rst_pkg.sv
// pulpemu_rst_pkg: shared state encoding and widths for the emulation reset generator.
package pulpemu_rst_pkg;
    typedef enum logic [1:0] {
        RST_HOLD    = 2'b00,
        RST_STRETCH = 2'b01,
        RST_RUN     = 2'b10
    } rst_state_e;
    localparam int unsigned RST_CNT_W = 8;
endpackage

// File: rtl/pulpemu_rst_debounce.sv
// pulpemu_rst_debounce: synchroniser followed by a stable-level debouncer.
module pulpemu_rst_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter logic        RST_VAL         = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    // The chain starts at the debounced reset value so no edge is seen until real data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= {SYNC_STAGES{RST_VAL}};
            cnt   <= '0;
            level <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (sync[SYNC_STAGES-1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pulpemu_rst_gen.sv
// pulpemu_rst_gen: board reset generator (button debounce, lock gating, reset stretch).
// Define PULPEMU_RST_CNT_EN to build the saturating reset-episode counter on rst_cnt_o.
module pulpemu_rst_gen
    import pulpemu_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned STRETCH_CYCLES  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 btn_rst_i,
    input  logic                 clk_locked_i,
    output logic                 soc_rst_no,
    output logic [1:0]           rst_state_o,
    output logic [RST_CNT_W-1:0] rst_cnt_o
);
    localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
    rst_state_e             state, state_nx;
    logic [SW-1:0]          st_cnt;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   btn_db, locked_s, abort;

    pulpemu_rst_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b1)
    ) u_btn (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .din  (btn_rst_i),
        .level(btn_db)
    );

    assign locked_s    = lock_sync[SYNC_STAGES-1];
    assign abort       = btn_db || !locked_s;
    assign rst_state_o = state;

    // Abort outranks every other transition, including the final stretch cycle.
    always_comb begin
        state_nx = abort                  ? RST_HOLD :
                   state == RST_HOLD      ? RST_STRETCH :
                   state == RST_STRETCH   ? (st_cnt == SW'(STRETCH_CYCLES - 1) ? RST_RUN : RST_STRETCH) :
                   state == RST_RUN       ? RST_RUN : RST_HOLD;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync  <= '0;
            state      <= RST_HOLD;
            st_cnt     <= '0;
            soc_rst_no <= 1'b0;
        end else begin
            lock_sync  <= {lock_sync[SYNC_STAGES-2:0], clk_locked_i};
            state      <= state_nx;
            st_cnt     <= (state == RST_STRETCH && state_nx == RST_STRETCH) ? st_cnt + 1'b1 : '0;
            soc_rst_no <= state_nx == RST_RUN;
        end
    end

`ifdef PULPEMU_RST_CNT_EN
    logic [RST_CNT_W-1:0] rst_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt <= '0;
        end else if (state == RST_RUN && state_nx == RST_HOLD && rst_cnt != '1) begin
            rst_cnt <= rst_cnt + 1'b1;
        end
    end
    assign rst_cnt_o = rst_cnt;
`else
    assign rst_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pulpemu_rst_gen.sv
// tb_pulpemu_rst_gen: table-driven check of power-up, glitch, button, lock loss,
// async reset and episode-counter saturation with SYNC=2, DEBOUNCE=4, STRETCH=8.
module tb_pulpemu_rst_gen;
    logic       clk = 1'b0;
    logic       rst_n, btn, lock;
    logic       soc_rst_n;
    logic [1:0] state;
    logic [7:0] rst_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef PULPEMU_RST_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic       btn;
        logic       lock;
        logic       soc;
        logic [1:0] st;
        int         cnt;
    } vec_t;
    vec_t vecs[$];

    pulpemu_rst_gen #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .STRETCH_CYCLES (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_rst_i   (btn),
        .clk_locked_i(lock),
        .soc_rst_no  (soc_rst_n),
        .rst_state_o (state),
        .rst_cnt_o   (rst_cnt)
    );

    always #5 clk = ~clk;

    function automatic void add(int n, logic b, logic l, logic s, logic [1:0] st, int c);
        for (int i = 0; i < n; i++) vecs.push_back('{b, l, s, st, c});
    endfunction

    function automatic int ce(int c);
        return CNT_EN ? (c > 255 ? 255 : c) : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(logic b, logic l);
        btn  = b;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    task automatic run(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            step(vecs[i].btn, vecs[i].lock);
            check($sformatf("soc[%0d]", i), int'(soc_rst_n), int'(vecs[i].soc));
            check($sformatf("state[%0d]", i), int'(state), int'(vecs[i].st));
            check($sformatf("cnt[%0d]", i), int'(rst_cnt), ce(vecs[i].cnt));
        end
    endtask

    initial begin
        // power-up: edges 1..16, RUN from edge 15
        add(6, 0, 1, 0, 2'b00, 0);
        add(8, 0, 1, 0, 2'b01, 0);
        add(2, 0, 1, 1, 2'b10, 0);
        // 3-cycle glitch is rejected
        add(3, 1, 1, 1, 2'b10, 0);
        add(10, 0, 1, 1, 2'b10, 0);
        // 10-cycle press: falls on the 7th edge, rises on the 15th edge after release
        add(6, 1, 1, 1, 2'b10, 0);
        add(4, 1, 1, 0, 2'b00, 1);
        add(6, 0, 1, 0, 2'b00, 1);
        add(8, 0, 1, 0, 2'b01, 1);
        add(2, 0, 1, 1, 2'b10, 1);
        // 1-cycle lock loss in RUN: falls on the 3rd edge
        add(1, 0, 0, 1, 2'b10, 1);
        add(1, 0, 1, 1, 2'b10, 1);
        add(1, 0, 1, 0, 2'b00, 2);
        // lock loss seen in STRETCH at st_cnt=5 restarts the stretch
        add(5, 0, 1, 0, 2'b01, 2);
        add(1, 0, 0, 0, 2'b01, 2);
        add(1, 0, 1, 0, 2'b01, 2);
        add(1, 0, 1, 0, 2'b00, 2);
        // lock loss seen on the final stretch cycle beats the RUN transition
        add(6, 0, 1, 0, 2'b01, 2);
        add(1, 0, 0, 0, 2'b01, 2);
        add(1, 0, 1, 0, 2'b01, 2);
        add(1, 0, 1, 0, 2'b00, 2);
        add(8, 0, 1, 0, 2'b01, 2);
        add(2, 0, 1, 1, 2'b10, 2);

        rst_n = 1'b0;
        btn   = 1'b0;
        lock  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_soc", int'(soc_rst_n), 0);
        check("rst_state", int'(state), 0);
        check("rst_cnt", int'(rst_cnt), 0);
        rst_n = 1'b1;
        run(0, vecs.size());

        // async reset between edges takes effect with no clock edge
        check("pre_async_soc", int'(soc_rst_n), 1);
        rst_n = 1'b0;
        #2;
        check("async_soc", int'(soc_rst_n), 0);
        check("async_state", int'(state), 0);
        check("async_cnt", int'(rst_cnt), 0);
        #1;
        rst_n = 1'b1;
        run(0, 16);

        // 300 RUN->HOLD episodes via one-cycle lock drops
        for (int e = 1; e <= 300; e++) begin
            step(0, 0);
            repeat (11) step(0, 1);
            if (e == 1 || e == 255 || e == 300) begin
                check($sformatf("sat_cnt[%0d]", e), int'(rst_cnt), ce(e));
                check($sformatf("sat_soc[%0d]", e), int'(soc_rst_n), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
